// File: rtl/counter_prog.sv
// Programmable-limit up/down counter with wrap, saturate and one-shot terminal modes.
// q/wrap/done update one clk after the controlling inputs; tc is combinational from q, up and limit.
module counter_prog #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         enb,
  input  logic         up,
  input  logic [W-1:0] limit,
  input  logic [1:0]   mode,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         wrap,
  output logic         done
);

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [W-1:0] q_nxt;
  logic         wrap_nxt;
  logic         done_nxt;

  // A loaded value above limit counts as terminal when counting up.
  assign tc = up ? (q >= limit) : (q == '0);

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    done_nxt = done;
    if (clr) begin
      q_nxt    = RST_VAL;
      done_nxt = 1'b0;
    end else if (ld) begin
      q_nxt    = d;
      done_nxt = 1'b0;
    end else if (enb && !done) begin
      if (!tc) begin
        q_nxt = up ? q + 1'b1 : q - 1'b1;
      end else begin
        case (mode)
          MODE_SAT:     q_nxt = q;
          MODE_ONESHOT: done_nxt = 1'b1;
          default: begin
            q_nxt    = up ? '0 : limit;
            wrap_nxt = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= RST_VAL;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_counter_prog.sv
// Directed bench for counter_prog (W=8, RST_VAL=0).
module tb_counter_prog;

  logic       clk = 1'b0;
  logic       rst, clr, ld, enb, up;
  logic [7:0] d, limit;
  logic [1:0] mode;
  logic [7:0] q;
  logic       tc, wrap, done;

  int tests = 0;
  int fails = 0;

  counter_prog #(.W(8), .RST_VAL(8'd0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .enb(enb), .up(up),
    .limit(limit), .mode(mode), .q(q), .tc(tc), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] eq, input logic ew, input logic ed);
    tests++;
    if (q !== eq || wrap !== ew || done !== ed) begin
      fails++;
      $display("FAIL %s: q=%0d wrap=%b done=%b, expected q=%0d wrap=%b done=%b",
               name, q, wrap, done, eq, ew, ed);
    end
  endtask

  task automatic chk_tc(input string name, input logic et);
    tests++;
    if (tc !== et) begin
      fails++;
      $display("FAIL %s: tc=%b expected %b", name, tc, et);
    end
  endtask

  task automatic load(input logic [7:0] v);
    ld = 1'b1; d = v; enb = 1'b0;
    step();
    ld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step();
    rst = 1'b0;
    chk("reset", 8'd0, 1'b0, 1'b0);
    load(8'd37);
    chk("load37", 8'd37, 1'b0, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid", 8'd0, 1'b0, 1'b0);
    load(8'd37);
    clr = 1'b1; ld = 1'b1; d = 8'd9; enb = 1'b1;
    step();
    clr = 1'b0; ld = 1'b0; enb = 1'b0;
    chk("clr_over_ld", 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_up_wrap();
    logic [7:0] eq [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    logic       ew [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    limit = 8'd5; mode = 2'b00; up = 1'b1;
    load(8'd0);
    enb = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("up_wrap", eq[i], ew[i], 1'b0);
      chk_tc("up_wrap_tc", eq[i] == 8'd5);
    end
    enb = 1'b0;
  endtask

  task automatic test_down();
    logic [7:0] ewq [4] = '{8'd1, 8'd0, 8'd3, 8'd2};
    logic       eww [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] esq [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
    limit = 8'd3; up = 1'b0; mode = 2'b00;
    load(8'd2);
    enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("down_wrap", ewq[i], eww[i], 1'b0);
    end
    mode = 2'b01;
    load(8'd2);
    enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("down_sat", esq[i], 1'b0, 1'b0);
    end
    chk_tc("down_sat_tc", 1'b1);
    enb = 1'b0;
  endtask

  task automatic test_oneshot();
    limit = 8'd4; mode = 2'b10; up = 1'b1;
    load(8'd0);
    enb = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("os_count", 8'(i), 1'b0, 1'b0);
    end
    step();
    chk("os_done", 8'd4, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("os_hold", 8'd4, 1'b0, 1'b1);
    end
    mode = 2'b00;
    step();
    chk("os_mode_change", 8'd4, 1'b0, 1'b1);
    mode = 2'b10;
    load(8'd2);
    chk("os_reload", 8'd2, 1'b0, 1'b0);
    enb = 1'b1;
    step(); chk("os_resume3", 8'd3, 1'b0, 1'b0);
    step(); chk("os_resume4", 8'd4, 1'b0, 1'b0);
    step(); chk("os_done2", 8'd4, 1'b0, 1'b1);
    enb = 1'b0;
  endtask

  task automatic test_load();
    limit = 8'd100; up = 1'b1; mode = 2'b00; enb = 1'b1;
    ld = 1'b1; d = 8'd200;
    step();
    ld = 1'b0;
    chk("ld_over_limit", 8'd200, 1'b0, 1'b0);
    chk_tc("ld_over_limit_tc", 1'b1);
    step();
    chk("ld_over_wrap", 8'd0, 1'b1, 1'b0);
    enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("enb_off_hold", 8'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_edges();
    limit = 8'd255; up = 1'b1; mode = 2'b00;
    load(8'd254);
    enb = 1'b1;
    step(); chk("full_255", 8'd255, 1'b0, 1'b0);
    chk_tc("full_255_tc", 1'b1);
    step(); chk("full_wrap", 8'd0, 1'b1, 1'b0);
    enb = 1'b0;
    limit = 8'd0;
    load(8'd0);
    enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("limit0_wrap", 8'd0, 1'b1, 1'b0);
    end
    mode = 2'b01;
    step(); chk("limit0_sat", 8'd0, 1'b0, 1'b0);
    enb = 1'b0; mode = 2'b00;
    limit = 8'd10;
    load(8'd3);
    up = 1'b0; enb = 1'b1;
    step(); chk("toggle_up", 8'd2, 1'b0, 1'b0);
    up = 1'b1;
    step(); chk("toggle_back", 8'd3, 1'b0, 1'b0);
    enb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ld = 1'b0; enb = 1'b0; up = 1'b1;
    d = 8'd0; limit = 8'd0; mode = 2'b00;
    test_reset();
    test_up_wrap();
    test_down();
    test_oneshot();
    test_load();
    test_edges();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
